alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu.sv | 66 ++++++
 tb/tb_alu.sv | 123 ++++++++++++
 2 files changed

// File: rtl/alu.sv
// Six-control ALU: conditionally zero/invert each operand, AND or ADD them, optionally invert the result.
// Define ALU_OUT_REG_EN to register result/zr/ng; the default build is purely combinational.
module alu #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic [WIDTH-1:0] result,
    output logic             zr,
    output logic             ng
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] x2;
    logic [WIDTH-1:0] y1;
    logic [WIDTH-1:0] y2;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] out_c;
    logic             zr_c;
    logic             ng_c;

    // Operand conditioning, function, output inversion; the add carry-out is dropped.
    always_comb begin
        x1    = zx ? '0 : a;
        x2    = nx ? ~x1 : x1;
        y1    = zy ? '0 : b;
        y2    = ny ? ~y1 : y1;
        r     = f ? WIDTH'(x2 + y2) : (x2 & y2);
        out_c = no ? ~r : r;
        zr_c  = (out_c == '0);
        ng_c  = out_c[MSB];
    end

`ifdef ALU_OUT_REG_EN
    // Flags are registered alongside the result so all three always agree.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result <= '0;
            zr     <= 1'b1;
            ng     <= 1'b0;
        end else begin
            result <= out_c;
            zr     <= zr_c;
            ng     <= ng_c;
        end
    end
`else
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ rst_n;
    assign result         = out_c;
    assign zr             = zr_c;
    assign ng             = ng_c;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: directed vectors push expected results, a negedge monitor pops and compares.
// Works for both the combinational build and the ALU_OUT_REG_EN build.
module tb_alu;

    localparam int unsigned WIDTH = 16;
`ifdef ALU_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             zr;
        logic             ng;
        int               due;
        string            name;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             zx = 1'b0, nx = 1'b0, zy = 1'b0, ny = 1'b0, f = 1'b0, no = 1'b0;
    logic [WIDTH-1:0] result;
    logic             zr;
    logic             ng;

    int   cycle = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    alu #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b),
        .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
        .result(result), .zr(zr), .ng(ng)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Monitor: outputs are sampled mid-cycle; each entry is due on a known cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cycle) begin
            exp_t e;
            e = sb.pop_front();
            tests++;
            if (e.due < cycle) begin
                fails++;
                $display("FAIL %s: result not sampled on cycle %0d (now %0d)", e.name, e.due, cycle);
            end else if ({result, zr, ng} !== {e.res, e.zr, e.ng}) begin
                fails++;
                $display("FAIL %s: got result=%h zr=%b ng=%b, expected result=%h zr=%b ng=%b",
                         e.name, result, zr, ng, e.res, e.zr, e.ng);
            end
        end
    end

    // ctl = {zx, nx, zy, ny, f, no}; expected values are for a live (non-reset) output.
    task automatic issue(input string nm, input logic rn, input logic [WIDTH-1:0] va,
                         input logic [WIDTH-1:0] vb, input logic [5:0] ctl,
                         input logic [WIDTH-1:0] eres, input logic ezr, input logic eng);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rn;
        a     = va;
        b     = vb;
        {zx, nx, zy, ny, f, no} = ctl;
        e.res  = eres;
        e.zr   = ezr;
        e.ng   = eng;
`ifdef ALU_OUT_REG_EN
        if (!rn) begin
            e.res = '0;
            e.zr  = 1'b1;
            e.ng  = 1'b0;
        end
`endif
        e.due  = cycle + LAT;
        e.name = nm;
        sb.push_back(e);
    endtask

    initial begin
        issue("reset_state", 1'b0, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 1'b1, 1'b0);
        issue("and",         1'b1, 16'h00AA, 16'h0AA0, 6'b000000, 16'h00A0, 1'b0, 1'b0);
        issue("and_zero",    1'b1, 16'h00A0, 16'hA000, 6'b000000, 16'h0000, 1'b1, 1'b0);
        issue("add_neg",     1'b1, 16'h00A0, 16'hA000, 6'b000010, 16'hA0A0, 1'b0, 1'b1);
        issue("small_and",   1'b1, 16'h0007, 16'h0005, 6'b000000, 16'h0005, 1'b0, 1'b0);
        issue("small_add",   1'b1, 16'h0007, 16'h0005, 6'b000010, 16'h000C, 1'b0, 1'b0);
        issue("wrap",        1'b1, 16'hFFFF, 16'h0001, 6'b000010, 16'h0000, 1'b1, 1'b0);
        issue("const_one",   1'b1, 16'h1234, 16'hBEEF, 6'b111111, 16'h0001, 1'b0, 1'b0);
        issue("minus_one",   1'b1, 16'h1234, 16'h5678, 6'b111010, 16'hFFFF, 1'b0, 1'b1);
        // ~(~x + 0) collapses back to x
        issue("not_add_not", 1'b1, 16'h0005, 16'h0000, 6'b010011, 16'h0005, 1'b0, 1'b0);
        // ~(x + 0xFFFF) = -x
        issue("negate_x",    1'b1, 16'h0005, 16'h0009, 6'b001111, 16'hFFFB, 1'b0, 1'b1);
        issue("add_plain",   1'b1, 16'h1234, 16'h1111, 6'b000010, 16'h2345, 1'b0, 1'b0);
        issue("nand",        1'b1, 16'hFFFF, 16'h0F0F, 6'b000001, 16'hF0F0, 1'b0, 1'b1);
        issue("nx_and",      1'b1, 16'h00FF, 16'h0FF0, 6'b010000, 16'h0F00, 1'b0, 1'b0);
        issue("ny_add",      1'b1, 16'h0010, 16'h0003, 6'b000110, 16'h000C, 1'b0, 1'b0);
        issue("rst_hold",    1'b0, 16'h0007, 16'h0005, 6'b000010, 16'h000C, 1'b0, 1'b0);
        issue("rst_release", 1'b1, 16'h0007, 16'h0005, 6'b000010, 16'h000C, 1'b0, 1'b0);
        issue("add_big",     1'b1, 16'hFFFF, 16'hFFFF, 6'b000010, 16'hFFFE, 1'b0, 1'b1);
        issue("rst_mid",     1'b0, 16'hFFFF, 16'hFFFF, 6'b000010, 16'hFFFE, 1'b0, 1'b1);
        issue("after_rst",   1'b1, 16'h0007, 16'h0005, 6'b000000, 16'h0005, 1'b0, 1'b0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expected results never checked", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
